// File: rtl/serial_tx_arbiter_if.sv
// Requester-side bus of the shared serial transmitter: bit-rate enable,
// flattened per-requester frame inputs and the grant/ack/line outputs.
interface serial_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 5
);
    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   addr;
    logic [N_REQ*DATA_W-1:0]   data;
    logic [N_REQ-1:0]          last;
    logic [N_REQ-1:0]          grant;
    logic [N_REQ-1:0]          ack;
    logic                      serout;
    logic                      busy;

    modport master (
        output en, req, addr, data, last,
        input  grant, ack, serout, busy
    );

    modport slave (
        input  en, req, addr, data, last,
        output grant, ack, serout, busy
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin owner selection plus frame sequencer for one shared serial line:
// start bit, address, then data chunks each closed by a continuation bit.
//
// state   | meaning
// S_IDLE  | line high, waiting for any request
// S_START | start bit (0) on the line, owner granted
// S_ADDR  | address bits, MSB first
// S_DATA  | data chunk bits, MSB first
// S_CONT  | continuation bit: 0 = another chunk, 1 = end of frame
module serial_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 5
) (
    input logic                clk,
    input logic                rst,
    serial_tx_arbiter_if.slave bus
);
    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA,
        S_CONT
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               serout_q, serout_d;
    logic               busy_q, busy_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [ADDR_W-1:0]  addr_arr [N_REQ];
    logic [DATA_W-1:0]  data_arr [N_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [SH_W-1:0]    addr_algn;
    logic [SH_W-1:0]    data_algn;
    logic               load_word;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = bus.addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = bus.data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts at the pointer and wraps; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Fields are left-aligned so the line always takes the shift register MSB.
    assign addr_algn = SH_W'(addr_arr[win_idx]) << (SH_W - ADDR_W);
    assign data_algn = SH_W'(data_arr[owner_q]) << (SH_W - DATA_W);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        serout_d  = serout_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        load_word = 1'b0;
        case (state_q)
            S_IDLE: begin
                serout_d = 1'b1;
                if (win_found) begin
                    state_d  = S_START;
                    grant_d  = N_REQ'(1) << win_idx;
                    owner_d  = win_idx;
                    ptr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    shreg_d  = addr_algn;
                    serout_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_START: begin
                state_d  = S_ADDR;
                serout_d = shreg_q[SH_W-1];
                shreg_d  = shreg_q << 1;
                cnt_d    = '0;
            end
            S_ADDR: begin
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d   = S_DATA;
                    load_word = 1'b1;
                end else begin
                    serout_d = shreg_q[SH_W-1];
                    shreg_d  = shreg_q << 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d  = S_CONT;
                    serout_d = last_q;
                end else begin
                    serout_d = shreg_q[SH_W-1];
                    shreg_d  = shreg_q << 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_CONT: begin
                if (last_q) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    serout_d = 1'b1;
                end else begin
                    state_d   = S_DATA;
                    load_word = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                serout_d = 1'b1;
            end
        endcase
        // Owner's word is captured at chunk entry; its MSB goes out on this edge.
        if (load_word) begin
            serout_d = data_algn[SH_W-1];
            shreg_d  = data_algn << 1;
            last_d   = bus.last[owner_q];
            ack_d    = grant_q;
            cnt_d    = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            serout_q <= 1'b1;
            busy_q   <= 1'b0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
        end else if (bus.en) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            serout_q <= serout_d;
            busy_q   <= busy_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
        end else begin
            ack_q    <= '0;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = ack_q;
    assign bus.serout = serout_q;
    assign bus.busy   = busy_q;
endmodule
